// File: rtl/cond_exec_if.sv
// Bundle between the execute/issue stages and cond_exec_unit: status writes, condition queries, results.
// COND_NV_TRAP_EN adds the per-channel undef result.
interface cond_exec_if #(
   parameter int NUM_CH = 2
);
   logic                  stall;
   logic                  flush;
   logic                  s_we;
   logic [3:0]            s_in;
   logic [3:0]            s_mask;
   logic [NUM_CH-1:0]     q_valid;
   logic [4*NUM_CH-1:0]   q_cond;
   logic [NUM_CH-1:0]     r_valid;
   logic [NUM_CH-1:0]     r_pass;
   logic [3:0]            status;
`ifdef COND_NV_TRAP_EN
   logic [NUM_CH-1:0]     undef;

   modport master (
      output stall, flush, s_we, s_in, s_mask, q_valid, q_cond,
      input  r_valid, r_pass, status, undef
   );
   modport slave (
      input  stall, flush, s_we, s_in, s_mask, q_valid, q_cond,
      output r_valid, r_pass, status, undef
   );
`else
   modport master (
      output stall, flush, s_we, s_in, s_mask, q_valid, q_cond,
      input  r_valid, r_pass, status
   );
   modport slave (
      input  stall, flush, s_we, s_in, s_mask, q_valid, q_cond,
      output r_valid, r_pass, status
   );
`endif
endinterface

// File: rtl/cond_exec_unit.sv
// NZCV status register plus NUM_CH pipelined ARM condition-code evaluators with optional flag forwarding.
// COND_NV_TRAP_EN: code 1111 additionally raises undef for that result.
module cond_exec_unit #(
   parameter int NUM_CH = 2,
   parameter int LAT    = 1,
   parameter bit BYPASS = 1'b1
) (
   input logic      clk,
   input logic      rst,
   cond_exec_if.slave bus
);
   logic [3:0]        status_reg;
   logic [3:0]        status_next;
   logic              status_upd;
   logic [3:0]        flags;
   logic [NUM_CH-1:0] pass_w;

   logic [NUM_CH-1:0] v_reg [LAT];
   logic [NUM_CH-1:0] p_reg [LAT];

   function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
      logic n, z, c, v, res;
      {n, z, c, v} = f;
      res = 1'b0;
      case (code)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = c;
         4'b0011: res = ~c;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = c & ~z;
         4'b1001: res = ~c | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         4'b1110: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   assign status_upd  = bus.s_we & ~bus.stall;
   assign status_next = (status_reg & ~bus.s_mask) | (bus.s_in & bus.s_mask);
   // Forwarded flags let a query see the flag write made in the same cycle
   assign flags = (BYPASS && status_upd) ? status_next : status_reg;

   always_ff @(posedge clk) begin
      if (rst)
         status_reg <= 4'b0000;
      else if (status_upd)
         status_reg <= status_next;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign pass_w[gi] = bus.q_valid[gi] & cond_eval(bus.q_cond[4*gi +: 4], flags);
      end
   endgenerate

`ifdef COND_NV_TRAP_EN
   logic [NUM_CH-1:0] u_reg [LAT];
   logic [NUM_CH-1:0] undef_w;

   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_nv
         assign undef_w[gi] = bus.q_valid[gi] & (bus.q_cond[4*gi +: 4] == 4'b1111);
      end
   endgenerate
`endif

   // Flush beats stall for the result pipe; stall freezes every stage
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         for (int i = 0; i < LAT; i++) begin
            v_reg[i] <= '0;
            p_reg[i] <= '0;
`ifdef COND_NV_TRAP_EN
            u_reg[i] <= '0;
`endif
         end
      end else if (!bus.stall) begin
         v_reg[0] <= bus.q_valid;
         p_reg[0] <= pass_w;
`ifdef COND_NV_TRAP_EN
         u_reg[0] <= undef_w;
`endif
         for (int i = 1; i < LAT; i++) begin
            v_reg[i] <= v_reg[i-1];
            p_reg[i] <= p_reg[i-1];
`ifdef COND_NV_TRAP_EN
            u_reg[i] <= u_reg[i-1];
`endif
         end
      end
   end

   assign bus.status  = status_reg;
   assign bus.r_valid = v_reg[LAT-1];
   assign bus.r_pass  = v_reg[LAT-1] & p_reg[LAT-1];
`ifdef COND_NV_TRAP_EN
   assign bus.undef   = v_reg[LAT-1] & u_reg[LAT-1];
`endif

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench for cond_exec_unit: unit A uses LAT=1/BYPASS=1, unit B uses LAT=2/BYPASS=0.
module tb_cond_exec_unit;
   logic clk;
   logic rst;
   logic       stall, flush, s_we;
   logic [3:0] s_in, s_mask;
   logic [1:0] q_valid;
   logic [7:0] q_cond;

   int errors = 0;
   int checks = 0;

   cond_exec_if #(.NUM_CH(2)) ifa ();
   cond_exec_if #(.NUM_CH(2)) ifb ();

   assign ifa.stall = stall;   assign ifb.stall = stall;
   assign ifa.flush = flush;   assign ifb.flush = flush;
   assign ifa.s_we = s_we;     assign ifb.s_we = s_we;
   assign ifa.s_in = s_in;     assign ifb.s_in = s_in;
   assign ifa.s_mask = s_mask; assign ifb.s_mask = s_mask;
   assign ifa.q_valid = q_valid; assign ifb.q_valid = q_valid;
   assign ifa.q_cond = q_cond; assign ifb.q_cond = q_cond;

   cond_exec_unit #(.NUM_CH(2), .LAT(1), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   cond_exec_unit #(.NUM_CH(2), .LAT(2), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else
         $display("ok   %s: %0h", tag, got);
   endtask

   // Reference: code[3:1] picks the base condition, code[0] inverts it
   function automatic logic ref_pass(input logic [3:0] code, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (code[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return base ^ code[0];
   endfunction

   task automatic idle();
      s_we = 1'b0; q_valid = 2'b00; stall = 1'b0; flush = 1'b0;
   endtask

   logic [1:0] exp_pass;

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      s_we = 1'b1; s_in = 4'hF; s_mask = 4'hF; q_valid = 2'b11; q_cond = 8'hEE;

      // 1: reset overrides write and queries
      repeat (2) @(negedge clk);
      check("rst_rvalid_during", {30'd0, ifa.r_valid}, 32'h0);
      rst = 1'b0; idle();
      @(negedge clk);
      check("rst_status_a", {28'd0, ifa.status}, 32'h0);
      check("rst_rvalid_a", {30'd0, ifa.r_valid}, 32'h0);
      check("rst_status_b", {28'd0, ifb.status}, 32'h0);
      check("rst_rvalid_b", {30'd0, ifb.r_valid}, 32'h0);

      // 2: every code against every flag value, back-to-back queries
      for (int s = 0; s < 16; s++) begin
         s_we = 1'b1; s_in = 4'(s); s_mask = 4'hF; q_valid = 2'b00;
         @(negedge clk);
         s_we = 1'b0;
         check($sformatf("sweep_status_%0d", s), {28'd0, ifa.status}, 32'(s));
         for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
               check($sformatf("sweep_rvalid_s%0d_c%0d", s, c-1), {30'd0, ifa.r_valid}, 32'h3);
               check($sformatf("sweep_rpass_s%0d_c%0d", s, c-1), {30'd0, ifa.r_pass}, {30'd0, exp_pass});
            end
            if (c < 16) begin
               q_valid = 2'b11;
               q_cond = {4'(15 - c), 4'(c)};
               exp_pass = {ref_pass(4'(15 - c), 4'(s)), ref_pass(4'(c), 4'(s))};
            end else
               q_valid = 2'b00;
            @(negedge clk);
         end
      end

      // 3: same-cycle forwarding (A) versus registered flags (B)
      s_we = 1'b1; s_in = 4'b0000; s_mask = 4'hF; q_valid = 2'b00;
      @(negedge clk);
      s_we = 1'b1; s_in = 4'b0100; s_mask = 4'hF; q_valid = 2'b11; q_cond = 8'h00;
      @(negedge clk);
      idle();
      check("fwd_rpass_a", {30'd0, ifa.r_pass}, 32'h3);
      check("fwd_status_a", {28'd0, ifa.status}, 32'h4);
      check("fwd_status_b", {28'd0, ifb.status}, 32'h4);
      check("fwd_rvalid_b_lat1", {30'd0, ifb.r_valid}, 32'h0);
      @(negedge clk);
      check("fwd_rvalid_b_lat2", {30'd0, ifb.r_valid}, 32'h3);
      check("fwd_rpass_b", {30'd0, ifb.r_pass}, 32'h0);

      // 4: masked write, then an all-zero mask
      s_we = 1'b1; s_in = 4'b1010; s_mask = 4'hF;
      @(negedge clk);
      s_we = 1'b1; s_in = 4'b0101; s_mask = 4'b0011;
      @(negedge clk);
      check("mask_status", {28'd0, ifa.status}, 32'h9);
      s_we = 1'b1; s_in = 4'hF; s_mask = 4'b0000; q_valid = 2'b11; q_cond = 8'h10;
      @(negedge clk);
      idle();
      check("mask0_status", {28'd0, ifa.status}, 32'h9);
      check("mask0_rpass", {30'd0, ifa.r_pass}, 32'h2);

      // 5: stall holds everything, flush drops in-flight results
      @(negedge clk);
      q_valid = 2'b11; q_cond = 8'hEE;
      @(negedge clk);
      check("stall_pre_rvalid", {30'd0, ifa.r_valid}, 32'h3);
      stall = 1'b1; s_we = 1'b1; s_in = 4'h0; s_mask = 4'hF; q_valid = 2'b11; q_cond = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("stall_rvalid_%0d", i), {30'd0, ifa.r_valid}, 32'h3);
         check($sformatf("stall_rpass_%0d", i), {30'd0, ifa.r_pass}, 32'h3);
         check($sformatf("stall_status_%0d", i), {28'd0, ifa.status}, 32'h9);
         check($sformatf("stall_rvalid_b_%0d", i), {30'd0, ifb.r_valid}, 32'h0);
      end
      flush = 1'b1;
      @(negedge clk);
      check("flush_rvalid_a", {30'd0, ifa.r_valid}, 32'h0);
      check("flush_rpass_a", {30'd0, ifa.r_pass}, 32'h0);
      check("flush_status", {28'd0, ifa.status}, 32'h9);
      idle();
      @(negedge clk);
      check("flush_after_a", {30'd0, ifa.r_valid}, 32'h0);
      check("flush_after_b", {30'd0, ifb.r_valid}, 32'h0);
      @(negedge clk);
      check("flush_after2_b", {30'd0, ifb.r_valid}, 32'h0);

      // 6: code 1111 on ch1, 1110 on ch0
      q_valid = 2'b11; q_cond = 8'hFE;
      @(negedge clk);
      idle();
      check("nv_rpass", {30'd0, ifa.r_pass}, 32'h1);
`ifdef COND_NV_TRAP_EN
      check("nv_undef", {30'd0, ifa.undef}, 32'h2);
      @(negedge clk);
      check("nv_undef_idle", {30'd0, ifa.undef}, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
